// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin time-sharing of one external flex_counter among
// NUM_REQ requesters, each needing a timed interval of programmable length.
module timer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_len,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic                         busy,
  output logic                         cnt_clear,
  output logic                         cnt_enable,
  output logic [NUM_BITS-1:0]          cnt_rollover_val,
  input  logic                         cnt_rollover_flag
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEANUP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx, r_ptr, w_sel, w_j;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_BITS-1:0] r_len;
  logic [NUM_BITS-1:0] w_lens [NUM_REQ];
  logic r_cmp;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign w_lens[g] = req_len[g*NUM_BITS +: NUM_BITS];
  end
  // Descending scan so the candidate closest to r_ptr (wrapping) wins last.
  always_comb begin
    w_sel = r_ptr;
    w_j = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_j = IW'((int'(r_ptr) + k) % NUM_REQ);
      w_sel = req[w_j] ? w_j : w_sel;
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = |req ? LOAD : IDLE;
      LOAD:    w_next = req[r_idx] ? RUN : CLEANUP;
      RUN:     w_next = (cnt_rollover_flag || !req[r_idx]) ? CLEANUP : RUN;
      CLEANUP: w_next = IDLE;
    endcase
    busy = r_state != IDLE;
    cnt_clear = r_state == LOAD || r_state == CLEANUP;
    cnt_enable = r_state == RUN && !cnt_rollover_flag;
    done = (r_state == CLEANUP && r_cmp) ? r_grant : '0;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_idx <= '0;
      r_ptr <= '0;
      r_grant <= '0;
      r_len <= '0;
      r_cmp <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (|req) begin
          r_idx <= w_sel;
          r_grant <= NUM_REQ'(1) << w_sel;
          r_len <= w_lens[w_sel] == '0 ? NUM_BITS'(1) : w_lens[w_sel];
        end
        RUN: if (cnt_rollover_flag) r_cmp <= 1'b1;
        CLEANUP: begin
          r_ptr <= r_idx == IW'(NUM_REQ-1) ? '0 : r_idx + 1'b1;
          r_grant <= '0;
          r_len <= '0;
          r_cmp <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  assign grant = r_grant;
  assign cnt_rollover_val = r_len;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed and random stimulus against a timeline reference model;
// a behavioural flex_counter closes the loop on the counter interface.
module tb_timer_arbiter;
  localparam int NR = 4;
  localparam int NB = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*NB-1:0] req_len = '0;
  logic [NR-1:0] grant, done;
  logic busy, cnt_clear, cnt_enable, cnt_rollover_flag;
  logic [NB-1:0] cnt_rollover_val, cnt, nc;
  int n_chk = 0, n_err = 0;
  int cyc = 0, t0 = 0, prev_done = -1;
  int last_done [NR] = '{default: -1};
  bit auto_drop = 1, fair = 0;
  bit m_busy = 0, m_cmp = 0;
  int m_own = 0, m_start = 0, m_len = 0, m_end = 0, m_ptr = 0;
  logic [NR-1:0] m_done_last = '0;

  always #5 clk = ~clk;

  timer_arbiter #(.NUM_REQ(NR), .NUM_BITS(NB)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_len(req_len), .grant(grant), .done(done),
    .busy(busy), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .cnt_rollover_val(cnt_rollover_val), .cnt_rollover_flag(cnt_rollover_flag)
  );

  always_comb nc = cnt_clear ? '0 : !cnt_enable ? cnt : (cnt == cnt_rollover_val ? NB'(1) : cnt + 1'b1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      cnt_rollover_flag <= 1'b0;
    end else begin
      cnt <= nc;
      cnt_rollover_flag <= !cnt_clear && nc == cnt_rollover_val;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic setlen(input int i, input int l);
    req_len[i*NB +: NB] = NB'(l);
  endtask

  // One clock cycle: compare against the timeline model, then advance it.
  task automatic step();
    logic [NR-1:0] eg, ed;
    logic ec, ee, eb;
    int ev, rel, lenv;
    bit found;
    #1;
    eg = '0; ed = '0; ec = 0; ee = 0; eb = 0; ev = 0;
    rel = cyc - m_start;
    if (m_busy) begin
      eg = NR'(1) << m_own;
      eb = 1;
      ev = m_len;
      ec = rel == 1 || cyc == m_end;
      ee = rel >= 2 && rel <= m_len + 1 && cyc < m_end;
      ed = (cyc == m_end && m_cmp) ? eg : '0;
    end
    check("grant", 32'(grant), 32'(eg));
    check("done", 32'(done), 32'(ed));
    check("busy", 32'(busy), 32'(eb));
    check("clear", 32'(cnt_clear), 32'(ec));
    check("enable", 32'(cnt_enable), 32'(ee));
    check("rollover_val", 32'(cnt_rollover_val), ev);
    for (int i = 0; i < NR; i++)
      if (done[i]) begin
        if (fair && prev_done >= 0) check("fair_gap", cyc - prev_done, 5);
        prev_done = cyc;
        last_done[i] = cyc;
      end
    m_done_last = ed;
    if (!m_busy) begin
      if (req != '0) begin
        found = 0;
        for (int k = 0; k < NR; k++)
          if (!found && req[(m_ptr + k) % NR]) begin
            found = 1;
            m_own = (m_ptr + k) % NR;
          end
        lenv = int'(req_len[m_own*NB +: NB]);
        m_len = lenv == 0 ? 1 : lenv;
        m_start = cyc;
        m_end = cyc + m_len + 3;
        m_cmp = 1;
        m_busy = 1;
      end
    end else if (cyc == m_end) begin
      m_busy = 0;
      m_ptr = (m_own + 1) % NR;
    end else if (rel <= m_len + 1 && !req[m_own]) begin
      m_end = cyc + 1;
      m_cmp = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      if (auto_drop) req &= ~m_done_last;
      step();
    end
  endtask

  initial begin
    @(negedge clk);
    step();
    n_rst = 1'b1;
    // contention: req[0] len 2 and req[2] len 5
    setlen(0, 2); setlen(2, 5); req = 4'b0101; t0 = cyc;
    run(16);
    check("cont_done0", last_done[0] - t0, 5);
    check("cont_done2", last_done[2] - t0, 14);
    // single request, len 3
    setlen(0, 3); req = 4'b0001; t0 = cyc;
    run(8);
    check("single_done", last_done[0] - t0, 6);
    // zero length loads as 1
    setlen(0, 0); req = 4'b0001; t0 = cyc;
    run(2);
    check("zero_rv", 32'(cnt_rollover_val), 1);
    run(4);
    check("zero_done", last_done[0] - t0, 4);
    // abort after 3 enabled cycles, then req[0] wraps from ptr 2
    setlen(1, 8); req = 4'b0010; last_done[1] = -1; t0 = cyc;
    run(5);
    req = '0;
    run(3);
    check("abort_nodone", last_done[1], -1);
    setlen(0, 3); req = 4'b0001; t0 = cyc;
    run(8);
    check("after_abort_done", last_done[0] - t0, 6);
    // fairness: all requesting permanently, length 1
    for (int i = 0; i < NR; i++) setlen(i, 1);
    auto_drop = 0; fair = 1; prev_done = -1; req = '1;
    run(25);
    fair = 0; auto_drop = 1; req = '0;
    run(8);
    // asynchronous reset in the middle of RUN
    setlen(3, 8); req = 4'b1000;
    run(5);
    #2 n_rst = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_clear", 32'(cnt_clear), 0);
    check("rst_enable", 32'(cnt_enable), 0);
    check("rst_rv", 32'(cnt_rollover_val), 0);
    m_busy = 0; m_ptr = 0; m_done_last = '0;
    @(negedge clk);
    n_rst = 1'b1; t0 = cyc;
    run(13);
    check("post_rst_done3", last_done[3] - t0, 11);
    // random traffic, with req_len churning while held
    repeat (800) begin
      for (int i = 0; i < NR; i++)
        if (req[i] && m_done_last[i]) req[i] = $urandom_range(0, 3) == 0;
        else if (req[i]) begin
          if ($urandom_range(0, 60) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
      if ($urandom_range(0, 3) == 0) req_len = (NR*NB)'($urandom);
      step();
    end
    req = '0;
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
